pkt_to_msg: RTL

Receive-side counterpart of the NIC's message-to-packet conversion. Accepts a packet from the router ejection port as a flit stream under a valid/ready handshake. Reassembles address, data burst and byte selects into one flat Wishbone message, then holds it until the NIC's WB master logic acknowledges it. Sits between the network ejection buffer and the NIC WB master FSM.

---
 rtl/pkt_to_msg.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pkt_to_msg.sv
`default_nettype none
// ============================================================================
// Module   : pkt_to_msg
// Purpose  : Reassembles an ejected flit stream into one flat Wishbone message
//            and holds it until the WB master acknowledges it.
// Revision : 1.0 - initial release
// ============================================================================
module pkt_to_msg #(
  parameter int BUS_DATA_WIDTH    = 32,
  parameter int BUS_SEL_WIDTH     = 4,
  parameter int BUS_ADDRESS_WIDTH = 32,
  parameter int MAX_BURST_LENGTH  = 8,
  parameter int FLIT_WIDTH        = 36,
  parameter int LEN_WIDTH         = 4
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic [FLIT_WIDTH-1:0]                       flit_i,
  input  logic [1:0]                                  flit_type_i,
  input  logic                                        flit_valid_i,
  output logic                                        flit_ready_o,
  output logic [MAX_BURST_LENGTH*BUS_DATA_WIDTH-1:0]  data_o,
  output logic [BUS_ADDRESS_WIDTH-1:0]                address_o,
  output logic [MAX_BURST_LENGTH*BUS_SEL_WIDTH-1:0]   sel_o,
  output logic [LEN_WIDTH-1:0]                        burst_len_o,
  output logic                                        msg_valid_o,
  input  logic                                        msg_ack_i,
  output logic                                        err_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t                                      r_state;
  state_t                                      w_next;
  logic [MAX_BURST_LENGTH*BUS_DATA_WIDTH-1:0]  r_data;
  logic [MAX_BURST_LENGTH*BUS_SEL_WIDTH-1:0]   r_sel;
  logic [BUS_ADDRESS_WIDTH-1:0]                r_addr;
  logic [LEN_WIDTH-1:0]                        r_count;
  logic                                        r_ovf;
  logic                                        r_err;

  logic w_acc;
  logic w_is_head;
  logic w_is_tail;
  logic w_head_acc;
  logic w_word_acc;
  logic w_room;
  logic w_err;

  // flit_type_i bit 0 marks a head, bit 1 marks a tail
  assign w_is_head  = flit_type_i[0];
  assign w_is_tail  = flit_type_i[1];
  assign w_acc      = flit_valid_i && (r_state != S_HOLD);
  assign w_head_acc = w_acc && w_is_head;
  assign w_word_acc = w_acc && !w_is_head && (r_state == S_COLLECT);
  assign w_room     = (r_count < LEN_WIDTH'(MAX_BURST_LENGTH));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if (w_is_head) begin
            w_next = w_is_tail ? S_HOLD : S_COLLECT;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        if (w_acc) begin
          if (w_is_head) begin
            w_next = w_is_tail ? S_HOLD : S_COLLECT;
            w_err  = 1'b1;
          end else if (w_is_tail) begin
            w_next = S_HOLD;
            // overflow is reported once, when the message is sealed
            w_err  = r_ovf || !w_room;
          end
        end
      end
      S_HOLD: begin
        if (msg_ack_i) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data  <= '0;
      r_sel   <= '0;
      r_addr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_err;
      if (w_head_acc) begin
        r_addr  <= flit_i[BUS_ADDRESS_WIDTH-1:0];
        r_data  <= '0;
        r_sel   <= '0;
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if (w_word_acc) begin
        if (w_room) begin
          for (int k = 0; k < MAX_BURST_LENGTH; k++) begin
            if (r_count == LEN_WIDTH'(k)) begin
              r_data[k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= flit_i[BUS_DATA_WIDTH-1:0];
              r_sel[k*BUS_SEL_WIDTH +: BUS_SEL_WIDTH]    <= flit_i[FLIT_WIDTH-1 -: BUS_SEL_WIDTH];
            end
          end
          r_count <= r_count + LEN_WIDTH'(1);
        end
        r_ovf <= w_is_tail ? 1'b0 : (r_ovf || !w_room);
      end
    end
  end

  assign flit_ready_o = (r_state != S_HOLD);
  assign msg_valid_o  = (r_state == S_HOLD);
  assign data_o       = r_data;
  assign sel_o        = r_sel;
  assign address_o    = r_addr;
  assign burst_len_o  = r_count;
  assign err_o        = r_err;

endmodule
`default_nettype wire
